// File: rtl/stream_upsize_pkg.sv
`default_nettype none
// ==========================================================================
// stream_upsize_pkg - lane-order encodings and index/lane helper functions
// Rev 1.0
// ==========================================================================
package stream_upsize_pkg;

  localparam int unsigned LANE_ORDER_LOW_FIRST  = 0;
  localparam int unsigned LANE_ORDER_HIGH_FIRST = 1;

  // Lane index width; a single-lane word still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic int unsigned lane_map(input int unsigned idx,
                                           input int unsigned ratio,
                                           input int unsigned order);
    return (order == LANE_ORDER_HIGH_FIRST) ? (ratio - 1 - idx) : idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ==========================================================================
// stream_out_reg - single-entry valid/ready holding register, zeroed when empty
// Rev 1.0
// ==========================================================================
module stream_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_valid ? in_data : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_upsize_pkt.sv
`default_nettype none
// ==========================================================================
// stream_upsize_pkt - packs narrow beats into a wide word with per-lane keep
// Rev 1.0
// ==========================================================================
module stream_upsize_pkt
  import stream_upsize_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_DATA_RATIO = 4,
  parameter int unsigned LANE_ORDER   = LANE_ORDER_LOW_FIRST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic                    flush_i,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IDX_W    = idx_width(T_DATA_RATIO);
  localparam int unsigned WORD_W   = T_DATA_WIDTH * T_DATA_RATIO + T_DATA_RATIO + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(T_DATA_RATIO - 1);

  logic [T_DATA_WIDTH-1:0] acc_data [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] data_nx  [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] acc_keep, keep_nx;
  logic                    acc_last, last_nx;
  logic [IDX_W-1:0]        idx, idx_nx, lane;
  logic                    done, done_nx;
  logic                    accept, xfer, out_free;
  logic [WORD_W-1:0]       acc_word, out_word;

  // A done word can still take a beat when the output register is empty,
  // because the transfer at that edge is guaranteed.
  assign s_ready_o = !(done && m_valid_o);
  assign accept    = s_valid_i && s_ready_o;
  assign xfer      = done && out_free;

  always_comb begin
    data_nx = acc_data;
    keep_nx = acc_keep;
    last_nx = acc_last;
    idx_nx  = idx;
    done_nx = done;
    lane    = '0;
    if (xfer) begin
      for (int i = 0; i < int'(T_DATA_RATIO); i++) data_nx[i] = '0;
      keep_nx = '0;
      last_nx = 1'b0;
      idx_nx  = '0;
      done_nx = 1'b0;
    end
    if (accept) begin
      lane          = IDX_W'(lane_map(32'(idx_nx), T_DATA_RATIO, LANE_ORDER));
      data_nx[lane] = s_data_i;
      keep_nx[lane] = 1'b1;
      done_nx       = (idx_nx == IDX_LAST) || s_last_i || flush_i;
      last_nx       = s_last_i;
      idx_nx        = idx_nx + 1'b1;
    end else if (flush_i && (keep_nx != '0)) begin
      done_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(T_DATA_RATIO); i++) acc_data[i] <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      idx      <= '0;
      done     <= 1'b0;
    end else begin
      acc_data <= data_nx;
      acc_keep <= keep_nx;
      acc_last <= last_nx;
      idx      <= idx_nx;
      done     <= done_nx;
    end
  end

  for (genvar g = 0; g < int'(T_DATA_RATIO); g++) begin : g_lane
    assign acc_word[g*T_DATA_WIDTH + T_DATA_RATIO + 1 +: T_DATA_WIDTH] = acc_data[g];
    assign m_data_o[g] = out_word[g*T_DATA_WIDTH + T_DATA_RATIO + 1 +: T_DATA_WIDTH];
  end
  assign acc_word[T_DATA_RATIO:1] = acc_keep;
  assign acc_word[0]              = acc_last;
  assign m_keep_o                 = out_word[T_DATA_RATIO:1];
  assign m_last_o                 = out_word[0];

  stream_out_reg #(
    .WIDTH (WORD_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (acc_word),
    .in_valid  (done),
    .in_ready  (out_free),
    .out_data  (out_word),
    .out_valid (m_valid_o),
    .out_ready (m_ready_i)
  );

endmodule
`default_nettype wire
